// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous single-port RAM among three requesters.
// Optional RAM_ARB_CPU_PRIORITY_EN gives port 0 fixed priority; ports 1/2 round-robin.
`default_nettype none

module ram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [2:0]          Req,
  input  logic [2:0]          We,
  input  logic [3*ADDR_W-1:0] Addr,
  input  logic [3*DATA_W-1:0] WData,
  output logic [2:0]          Gnt,
  output logic [2:0]          RValid,
  output logic [DATA_W-1:0]   RData,
  output logic                Busy,
  output logic [ADDR_W-1:0]   RamAddr,
  output logic                RamWe,
  output logic [DATA_W-1:0]   RamWData,
  input  logic [DATA_W-1:0]   RamRData
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_idx;
  logic [1:0]        w_win;
  logic              w_accept;

  assign w_accept = (r_state == S_IDLE) && (|Req);

`ifdef RAM_ARB_CPU_PRIORITY_EN
  // High when port 2 was the last of the pair 1/2 to win, so port 1 goes first out of reset.
  logic r_last12;

  always_comb begin
    w_win = 2'd0;
    if (Req[0])
      w_win = 2'd0;
    else if (Req[1] && Req[2])
      w_win = r_last12 ? 2'd1 : 2'd2;
    else if (Req[1])
      w_win = 2'd1;
    else
      w_win = 2'd2;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_last12 <= 1'b1;
    else if (w_accept && !Req[0])
      r_last12 <= (w_win == 2'd2);
  end
`else
  logic [1:0] r_last_winner;
  logic [1:0] w_first;
  logic [1:0] w_second;
  logic [1:0] w_third;

  always_comb begin
    w_first  = (r_last_winner == 2'd2) ? 2'd0 : r_last_winner + 2'd1;
    w_second = (w_first == 2'd2) ? 2'd0 : w_first + 2'd1;
    w_third  = (w_second == 2'd2) ? 2'd0 : w_second + 2'd1;
    if (Req[w_first])
      w_win = w_first;
    else if (Req[w_second])
      w_win = w_second;
    else
      w_win = w_third;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_last_winner <= 2'd2;
    else if (w_accept)
      r_last_winner <= w_win;
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_idx   <= 2'd0;
    end else if (w_accept) begin
      r_we    <= We[w_win];
      r_addr  <= Addr[w_win*ADDR_W +: ADDR_W];
      r_wdata <= WData[w_win*DATA_W +: DATA_W];
      r_idx   <= w_win;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    w_next_state = (|Req) ? S_ISSUE : S_IDLE;
      S_ISSUE:   w_next_state = r_we ? S_IDLE : S_CAPTURE;
      S_CAPTURE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // RAM address/data follow the latched request at all times; strobes decode the state.
  always_comb begin
    Gnt      = 3'b000;
    RValid   = 3'b000;
    RData    = '0;
    RamWe    = 1'b0;
    Busy     = (r_state != S_IDLE);
    RamAddr  = r_addr;
    RamWData = r_wdata;
    case (r_state)
      S_ISSUE: begin
        Gnt   = 3'b001 << r_idx;
        RamWe = r_we;
      end
      S_CAPTURE: begin
        RValid = 3'b001 << r_idx;
        RData  = RamRData;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the CPU's single-port 16-bit data RAM among three requesters: CPU load/store (port 0), video read-out (port 1) and I/O/DMA (port 2). The block registers one request at a time, drives the RAM port and returns read data with a per-port valid strobe. It sits between the CPU datapath's RAM address/data path, the display fetch logic and the RAM macro.

## Interface
Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 16, RAM data width.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Req  input  3  request per port; bit i = port i.
- We  input  3  per-port write enable; 1 = write, 0 = read; sampled with Req.
- Addr  input  3*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- WData  input  3*DATA_W  per-port write data; same packing as Addr.
- Gnt  output  3  one-hot, one-cycle pulse when the port's access is issued to RAM.
- RValid  output  3  one-hot, one-cycle pulse when RData holds the port's read result.
- RData  output  DATA_W  read data, shared by all ports; meaningful only with RValid.
- Busy  output  1  high in any state other than IDLE.
- RamAddr  output  ADDR_W  RAM address.
- RamWe  output  1  RAM write enable.
- RamWData  output  DATA_W  RAM write data.
- RamRData  input  DATA_W  RAM read data; synchronous RAM, valid the cycle after the address is presented.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: if any Req bit is set, pick a winner, latch its We/Addr/WData into internal registers along with the winner index, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive RamAddr/RamWData from the latched values. RamWe = latched We. Gnt[winner] = 1. Next state: CAPTURE for a read, IDLE for a write.
- CAPTURE: RValid[winner] = 1 and RData = RamRData (combinational pass-through). Next state: IDLE.
- Arbitration is round-robin. The search starts at (last_winner + 1) mod 3. last_winner updates on IDLE→ISSUE. Its reset value is 2, so port 0 wins first.
- Handshake rules:
  - A requester holds Req, We, Addr and WData stable until it sees Gnt.
  - A requester deasserts Req the cycle after Gnt unless it has a new request.
  - Req high in the IDLE cycle that follows a completion counts as a new request.
  - A requester that drops Req before Gnt withdraws its request. If it was already latched, the access still completes.
- Inputs are sampled only in IDLE. Changes during ISSUE/CAPTURE have no effect.
- Outputs outside their active state: Gnt = 0, RValid = 0, RamWe = 0, RData = 0. RamAddr and RamWData hold their last latched value.
- Reset values: state IDLE, latched registers 0, last_winner 2, every output 0.
- Reset mid-operation: the FSM goes to IDLE immediately and RamWe drops asynchronously. An interrupted write is undefined and the requester must reissue it. No RValid is emitted for an interrupted read.

## Timing
- A request is sampled at edge N in IDLE. Gnt and the RAM drive occur in cycle N+1 (ISSUE).
- Read: RValid occurs in cycle N+2 (CAPTURE). The next request can be sampled at the end of N+2 at the earliest. Throughput is 1 read per 3 cycles.
- Write: the RAM write occurs at the end of cycle N+1. The next request can be sampled at the end of N+1 at the earliest. Throughput is 1 write per 2 cycles.
- When all three ports request continuously, each port is granted at least once every 3 arbitrations.
- All outputs are registered state decodes except RData, which is combinational from RamRData.

## Configuration
- Macro: RAM_ARB_CPU_PRIORITY_EN.
- Defined:
  - Port 0 wins whenever Req[0] is high in IDLE.
  - Ports 1 and 2 round-robin between themselves only when Req[0] is low. A separate 1-bit pointer tracks the last of ports 1/2 granted; its reset value selects port 1 first.
- Undefined: full three-way round-robin as described under Operation.

## Test plan
- Single read: preload RAM[0x0010] = 0xBEEF. Port 0 sets Req = 1, We = 0, Addr = 0x0010 → Gnt[0] 1 cycle later, RValid[0] 2 cycles later with RData = 0xBEEF, Busy high for 2 cycles.
- Write then read-back: port 2 writes 0x1234 to 0x00FF, then reads 0x00FF → RamWe pulses exactly once, then RValid[2] with RData = 0x1234.
- Contention: Req = 3'b111 held, all reads → Gnt order 0, 1, 2, 0, 1, 2. With RAM_ARB_CPU_PRIORITY_EN defined, the order is 0, 0, 0… while port 0 keeps requesting. After port 0 drops, the order is 1, 2, 1.
- Input change during ISSUE: Addr[0] changes from 0x0010 to 0x0020 in the Gnt cycle → RamAddr stays 0x0010 and RData is taken from 0x0010.
- Reset mid-read: assert Reset during CAPTURE → RValid goes low immediately and all outputs are 0. After release, a pending Req[1] is granted first only if Req[0] is low. last_winner = 2 again after reset, so port 0 wins if it requests.
- Idle stability: Req = 0 for 20 cycles → Busy, Gnt, RValid and RamWe stay 0 throughout.
